alu_iter: RTL and testbench
===========================

# alu_iter

Multi-cycle RV64 integer execution unit: the consumer of the 4-bit `aluctl` code that the ALU control decoder produces from `aluop`/`func3`/`func7`. It sits in the EX stage and accepts one operation at a time over a valid/ready handshake. Add, sub, logic and compare ops complete in one cycle. Shifts are iterative at one bit position per cycle, trading latency for area. It returns a 64-bit result and a zero flag, which branch resolution uses for beq/bne/blt/bge/bltu/bgeu.

## Interface
- `XLEN`, default 64: operand and result width; must be 32 or 64.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous kill of the in-flight operation (pipeline flush).
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `aluctl` in 4: operation code, using the `ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND` macros from `define.v`.
- `op_a` in XLEN: operand A / shift source.
- `op_b` in XLEN: operand B; shift amount is `op_b[$clog2(XLEN)-1:0]`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `result` out XLEN: registered result.
- `zero` out 1: registered, equals `result == 0`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, latch `aluctl`, `op_a`, `op_b`.
  - Non-shift op, or shift with shamt 0: compute the result, go to DONE.
  - Shift with shamt n>0: load the accumulator with `op_a` and the counter with n, go to SHIFT.
- SHIFT:
  - Each cycle: SLL shifts left 1 with zero fill; SRL shifts right 1 with zero fill; SRA shifts right 1 replicating the MSB. Decrement the counter.
  - When the counter reaches 1 this cycle, go to DONE.
- DONE:
  - `out_valid=1`; `result`/`zero` are stable.
  - On `out_ready`, go to IDLE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare, SLTU an unsigned compare; both produce 1 or 0, zero-extended.
  - XOR/OR/AND are bitwise.
- Any `aluctl` value not in the list above executes as ADD.
- `zero` is computed from the final result in the same cycle `result` is written.
- Operands latched at accept are used; `op_a`/`op_b`/`aluctl` may change after the accept cycle.

## Timing
- Reset (async assert, sync release): state IDLE, `in_ready=1`, `out_valid=0`, `result=0`, `zero=0`, counter 0.
- Accept happens in cycle T, when `in_valid && in_ready`.
- Non-shift or shamt 0: `out_valid=1` from T+1.
- Shift with shamt n≥1: `out_valid=1` from T+1+n. Maximum is T+XLEN for shamt XLEN-1.
- `result`/`zero` hold while `out_valid && !out_ready` (no bubbles, no change).
- Output handshake at cycle D: `out_valid=0` and `in_ready=1` at D+1. Back-to-back throughput is one op per 2 cycles minimum.
- `in_ready=0` in SHIFT and DONE; requests are ignored there.
- `flush`:
  - State goes to IDLE at the next edge and `out_valid` drops.
  - `result`/`zero` keep their old values.
  - Flush wins over a same-cycle accept, so the op is discarded.
  - Flush wins over a same-cycle output handshake; the result is considered not delivered.
- `rst_n` asserted mid-SHIFT or in DONE: immediate return to reset values; no partial result is visible.

## Structure
- `define.v` (shared, already included by the core) holds the `aluctl` op-code macros. Add a new state-encoding macro set `ALUI_IDLE/ALUI_SHIFT/ALUI_DONE` there.
- Natural sub-module `alu_comb`: a purely combinational single-cycle ALU (all ops, shifts by 0 or 1 only). `alu_iter` wraps it with the FSM, operand/accumulator registers and the shift counter.

## Test plan
- Reset, then ADD with `op_a=64'h7FFF_FFFF_FFFF_FFFF`, `op_b=1` -> `out_valid` at T+1, `result=64'h8000_0000_0000_0000`, `zero=0`.
- SUB with `op_a=op_b=64'h1234` -> `result=0`, `zero=1`. SLT with `op_a=-1`, `op_b=1` -> `result=1`. SLTU with the same operands -> `result=0`.
- SRA with `op_a=64'h8000_0000_0000_0000`, `op_b=63` -> `out_valid` exactly at T+64, `result=64'hFFFF_FFFF_FFFF_FFFF`. SRL with the same operands -> `result=1`. SLL with `op_b=0` -> `out_valid` at T+1, `result=op_a`.
- Hold `out_ready=0` for 5 cycles in DONE -> `result`/`out_valid` unchanged and `in_ready=0`. A new `in_valid` in that window is not accepted.
- `flush` at T+10 of an SLL by 40 -> `out_valid` never rises and `in_ready=1` at T+11. Next op ADD 2+3 returns 5 at its own T'+1.
- `rst_n` pulsed low mid-shift, asynchronously between edges -> `out_valid=0`, `result=0`, `in_ready=1` immediately. Unknown `aluctl=4'hF` with `op_a=2`, `op_b=3` -> `result=5`.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// Shared op-codes, FSM state encoding and helpers for the iterative ALU.
package alu_iter_pkg;

  // aluctl op-codes: {func7[5], func3} style encoding
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ALUI_IDLE  = 2'd0,
    ALUI_SHIFT = 2'd1,
    ALUI_DONE  = 2'd2
  } alui_state_e;

  // True for the ops that run on the iterative shifter
  function automatic logic is_shift(input logic [3:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational ALU; shifts move by i_b[0] (0 or 1) positions only.
module alu_comb
  import alu_iter_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [3:0]      i_ctl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y_c
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  // Operation select; unlisted codes fall back to ADD
  always_comb begin
    o_y_c = i_a + i_b;
    case (i_ctl)
      ALU_SUB:  o_y_c = i_a - i_b;
      ALU_SLT:  o_y_c = XLEN'(w_lt_s);
      ALU_SLTU: o_y_c = XLEN'(w_lt_u);
      ALU_XOR:  o_y_c = i_a ^ i_b;
      ALU_OR:   o_y_c = i_a | i_b;
      ALU_AND:  o_y_c = i_a & i_b;
      ALU_SLL:  o_y_c = i_b[0] ? {i_a[XLEN-2:0], 1'b0} : i_a;
      ALU_SRL:  o_y_c = i_b[0] ? {1'b0, i_a[XLEN-1:1]} : i_a;
      ALU_SRA:  o_y_c = i_b[0] ? {i_a[XLEN-1], i_a[XLEN-1:1]} : i_a;
      default:  o_y_c = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle RV integer execution unit: one-cycle arithmetic/logic, bit-serial shifts.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_aluctl,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  alui_state_e     r_state;
  alui_state_e     w_state_nxt;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_acc;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic [SHW-1:0]  w_shamt;
  logic            w_start_shift;
  logic            w_in_shift;
  logic [3:0]      w_ctl;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu_y;

  assign w_shamt       = i_op_b[SHW-1:0];
  assign w_start_shift = is_shift(i_aluctl) && (w_shamt != '0);
  assign w_in_shift    = (r_state == ALUI_SHIFT);

  // While shifting, the ALU steps the accumulator by one position
  assign w_ctl = w_in_shift ? r_op  : i_aluctl;
  assign w_a   = w_in_shift ? r_acc : i_op_a;
  assign w_b   = w_in_shift ? XLEN'(1) : i_op_b;

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .i_ctl (w_ctl),
    .i_a   (w_a),
    .i_b   (w_b),
    .o_y_c (w_alu_y)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ALUI_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ALUI_IDLE: begin
        if (i_in_valid) w_state_nxt = w_start_shift ? ALUI_SHIFT : ALUI_DONE;
      end
      ALUI_SHIFT: begin
        if (r_cnt == SHW'(1)) w_state_nxt = ALUI_DONE;
      end
      ALUI_DONE: begin
        if (i_out_ready) w_state_nxt = ALUI_IDLE;
      end
      default: w_state_nxt = ALUI_IDLE;
    endcase
    if (i_flush) w_state_nxt = ALUI_IDLE;
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ALUI_IDLE: o_in_ready  = 1'b1;
      ALUI_DONE: o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, shift iteration and result/zero registers; flush freezes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= ALU_ADD;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (!i_flush) begin
      case (r_state)
        ALUI_IDLE: begin
          if (i_in_valid) begin
            r_op  <= i_aluctl;
            r_acc <= i_op_a;
            if (w_start_shift) begin
              r_cnt <= w_shamt;
            end else begin
              r_cnt    <= '0;
              r_result <= w_alu_y;
              r_zero   <= (w_alu_y == '0);
            end
          end
        end
        ALUI_SHIFT: begin
          r_acc <= w_alu_y;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_result <= w_alu_y;
            r_zero   <= (w_alu_y == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, corner sequences, random ops.
module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_flush;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [3:0]      i_aluctl;
  logic [XLEN-1:0] i_op_a;
  logic [XLEN-1:0] i_op_b;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [XLEN-1:0] o_result;
  logic            o_zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_aluctl    (i_aluctl),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result),
    .o_zero      (o_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          wait_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: RISC-V semantics with the full shift amount applied at once
  function automatic logic [63:0] ref_res(input logic [3:0] ctl, input logic [63:0] a,
                                          input logic [63:0] b);
    int sh;
    sh = int'(b[5:0]);
    case (ctl)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      ALU_SLTU: return (a < b) ? 64'd1 : 64'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 64'($signed(a) >>> sh);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic int ref_wait(input logic [3:0] ctl, input logic [63:0] b);
    if ((ctl == ALU_SLL || ctl == ALU_SRL || ctl == ALU_SRA) && b[5:0] != 6'd0)
      return int'(b[5:0]);
    return 0;
  endfunction

  // Issue one op, measure latency after the accept edge, check result; optionally ack
  task automatic run_op(input string nm, input logic [3:0] ctl, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res,
                        input int exp_wait, input bit ack);
    int waited;
    @(negedge clk);
    i_aluctl   = ctl;
    i_op_a     = a;
    i_op_b     = b;
    i_in_valid = 1'b1;
    chk({nm, "_in_ready"}, 64'(o_in_ready), 64'd1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_aluctl   = 4'($urandom);
    i_op_a     = {$urandom, $urandom};
    i_op_b     = {$urandom, $urandom};
    waited = 0;
    while (!o_out_valid && waited < int'(XLEN) + 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk({nm, "_latency"}, 64'(waited), 64'(exp_wait));
    chk({nm, "_result"}, o_result, exp_res);
    chk({nm, "_zero"}, 64'(o_zero), 64'(exp_res == 64'd0));
    if (ack) begin
      i_out_ready = 1'b1;
      @(posedge clk);
      #1;
      i_out_ready = 1'b0;
      chk({nm, "_ack_valid"}, 64'(o_out_valid), 64'd0);
      chk({nm, "_ack_ready"}, 64'(o_in_ready), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] held;
    logic [3:0]  rc;
    logic [63:0] ra;
    logic [63:0] rb;

    rst_n = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_aluctl = '0; i_op_a = '0; i_op_b = '0;
    #12;
    chk("reset_in_ready", 64'(o_in_ready), 64'd1);
    chk("reset_out_valid", 64'(o_out_valid), 64'd0);
    chk("reset_result", o_result, 64'd0);
    chk("reset_zero", 64'(o_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{ALU_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0});
    vecs.push_back('{ALU_SUB,  64'h1234, 64'h1234, 64'd0, 0});
    vecs.push_back('{ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0});
    vecs.push_back('{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0});
    vecs.push_back('{ALU_SRA,  64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 63});
    vecs.push_back('{ALU_SRL,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 63});
    vecs.push_back('{ALU_SLL,  64'hDEAD_BEEF_0000_1234, 64'd0, 64'hDEAD_BEEF_0000_1234, 0});
    vecs.push_back('{ALU_SLL,  64'hDEAD_BEEF_0000_1234, 64'd64, 64'hDEAD_BEEF_0000_1234, 0});
    vecs.push_back('{ALU_SLL,  64'h1, 64'd4, 64'h10, 4});
    vecs.push_back('{ALU_SRA,  64'h0F00_0000_0000_0000, 64'd8, 64'h000F_0000_0000_0000, 8});
    vecs.push_back('{ALU_XOR,  64'hFF00, 64'h0FF0, 64'hF0F0, 0});
    vecs.push_back('{ALU_OR,   64'hFF00, 64'h0FF0, 64'hFFF0, 0});
    vecs.push_back('{ALU_AND,  64'hFF00, 64'h0FF0, 64'h0F00, 0});
    vecs.push_back('{ALU_SLT,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0});
    vecs.push_back('{4'hA,     64'd7, 64'd8, 64'd15, 0});

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].wait_cyc, 1'b1);

    // Hold result in DONE for 5 cycles with a competing request
    run_op("hold", ALU_ADD, 64'd10, 64'd20, 64'd30, 0, 1'b0);
    held = o_result;
    @(negedge clk);
    i_in_valid = 1'b1; i_aluctl = ALU_SUB; i_op_a = 64'd100; i_op_b = 64'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_result_%0d", k), o_result, held);
      chk($sformatf("hold_valid_%0d", k), 64'(o_out_valid), 64'd1);
      chk($sformatf("hold_in_ready_%0d", k), 64'(o_in_ready), 64'd0);
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_no_ghost_valid", 64'(o_out_valid), 64'd0);
    chk("hold_no_ghost_result", o_result, 64'd30);

    // Flush at T+10 of an SLL by 40
    @(negedge clk);
    i_aluctl = ALU_SLL; i_op_a = 64'h3; i_op_b = 64'd40; i_in_valid = 1'b1;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
      chk("flush_pre_valid", 64'(o_out_valid), 64'd0);
    end
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    chk("flush_in_ready", 64'(o_in_ready), 64'd1);
    chk("flush_out_valid", 64'(o_out_valid), 64'd0);
    chk("flush_result_kept", o_result, 64'd30);
    begin
      int seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (o_out_valid) seen++;
      end
      chk("flush_never_valid", 64'(seen), 64'd0);
    end
    run_op("post_flush_add", ALU_ADD, 64'd2, 64'd3, 64'd5, 0, 1'b1);

    // Flush beats a same-cycle accept
    @(negedge clk);
    i_aluctl = ALU_ADD; i_op_a = 64'd9; i_op_b = 64'd9; i_in_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0; i_flush = 1'b0;
    chk("flush_accept_ready", 64'(o_in_ready), 64'd1);
    chk("flush_accept_valid", 64'(o_out_valid), 64'd0);
    chk("flush_accept_result", o_result, 64'd5);

    // Flush beats a same-cycle output handshake
    run_op("flush_ack", ALU_XOR, 64'hF, 64'h3, 64'hC, 0, 1'b0);
    @(negedge clk);
    i_flush = 1'b1; i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0; i_out_ready = 1'b0;
    chk("flush_ack_valid", 64'(o_out_valid), 64'd0);
    chk("flush_ack_ready", 64'(o_in_ready), 64'd1);
    chk("flush_ack_result", o_result, 64'hC);

    // Asynchronous reset in the middle of a shift
    @(negedge clk);
    i_aluctl = ALU_SRL; i_op_a = 64'hFFFF_0000_FFFF_0000; i_op_b = 64'd50; i_in_valid = 1'b1;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(o_out_valid), 64'd0);
    chk("arst_result", o_result, 64'd0);
    chk("arst_zero", 64'(o_zero), 64'd0);
    chk("arst_in_ready", 64'(o_in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("unknown_ctl", 4'hF, 64'd2, 64'd3, 64'd5, 0, 1'b1);

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rc = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 4 == 0) rb = 64'($urandom_range(0, 2));
      run_op($sformatf("rand%0d", n), rc, ra, rb, ref_res(rc, ra, rb), ref_wait(rc, rb), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
